// File: rtl/tmds_channel_rx_if.sv
// Signal bundle for one TMDS receive lane: serial pair in, decoded symbols out.
interface tmds_channel_rx_if;
  logic [1:0] in_bits;
  logic       word_valid;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] bit_offset;

  // Source side: supplies the serial pair and consumes decoded symbols.
  modport master (
    output in_bits,
    input  word_valid, de, data, ctrl, locked, bit_offset
  );

  // Receiver side.
  modport slave (
    input  in_bits,
    output word_valid, de, data, ctrl, locked, bit_offset
  );
endinterface

// File: rtl/tmds_channel_rx.sv
// TMDS lane receiver.
// Assembles 10-bit symbols from 2-bit DDR pairs, finds the word boundary by
// hunting for runs of control tokens at one bit offset, and then decodes
// data, DE and the two control bits.
module tmds_channel_rx #(
  parameter int CTRL_RUN     = 8,
  parameter int SEARCH_WORDS = 64,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic             clk_x5,
  input  logic             reset,
  tmds_channel_rx_if.slave bus
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int SRCH_W = $clog2(SEARCH_WORDS + 1);
  localparam int IDLE_W = $clog2(LOCK_TIMEOUT + 1);

  // Counter values on the word that makes the count reach its limit.
  localparam logic [RUN_W-1:0]  RUN_LAST    = RUN_W'(CTRL_RUN - 1);
  localparam logic [SRCH_W-1:0] SEARCH_LAST = SRCH_W'(SEARCH_WORDS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Control token lookup: {is_token, ctrl}.
  function automatic logic [2:0] token_lookup(input logic [9:0] w);
    logic [2:0] r;
    case (w)
      10'b1101010100: r = 3'b100;
      10'b0010101011: r = 3'b101;
      10'b0101010100: r = 3'b110;
      10'b1010101011: r = 3'b111;
      default:        r = 3'b000;
    endcase
    return r;
  endfunction

  // TMDS data decode: undo the optional inversion, then the XOR/XNOR chain.
  function automatic logic [7:0] data_decode(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  state_t              state_r;
  logic [2:0]          phase_r;
  logic [19:0]         sr_r;
  logic [3:0]          offset_r;
  logic [RUN_W-1:0]    run_cnt_r;
  logic [SRCH_W-1:0]   search_cnt_r;
  logic [IDLE_W-1:0]   idle_cnt_r;
  logic                word_valid_r;
  logic                de_r;
  logic [7:0]          data_r;
  logic [1:0]          ctrl_r;
  logic                locked_r;

  logic [19:0]         sr_next_s;
  logic [9:0]          window_s;
  logic [2:0]          token_s;
  logic                is_token_s;
  logic [1:0]          token_ctrl_s;
  logic [7:0]          decoded_s;
  logic                capture_s;
  logic [3:0]          next_offset_s;

  // The capture edge sees the pair arriving on that same edge, so the window
  // is cut from the post-shift value; offset k ends k bits before the newest.
  assign sr_next_s    = {bus.in_bits[1], bus.in_bits[0], sr_r[19:2]};
  assign window_s     = sr_next_s[5'd19 - {1'b0, offset_r} -: 10];
  assign token_s      = token_lookup(window_s);
  assign is_token_s   = token_s[2];
  assign token_ctrl_s = token_s[1:0];
  assign decoded_s    = data_decode(window_s);
  assign capture_s    = (phase_r == 3'd4);

  // Next alignment offset, wrapping 9 back to 0.
  always_comb begin
    next_offset_s = 4'd0;
    if (offset_r == 4'd9) begin
      next_offset_s = 4'd0;
    end else begin
      next_offset_s = offset_r + 4'd1;
    end
  end

  // Deserializer, word-alignment FSM and registered symbol outputs.
  always_ff @(posedge clk_x5) begin
    if (reset) begin
      state_r      <= ST_SEARCH;
      phase_r      <= 3'd0;
      sr_r         <= 20'd0;
      offset_r     <= 4'd0;
      run_cnt_r    <= RUN_W'(0);
      search_cnt_r <= SRCH_W'(0);
      idle_cnt_r   <= IDLE_W'(0);
      word_valid_r <= 1'b0;
      de_r         <= 1'b0;
      data_r       <= 8'd0;
      ctrl_r       <= 2'd0;
      locked_r     <= 1'b0;
    end else begin
      sr_r         <= sr_next_s;
      word_valid_r <= 1'b0;
      if (capture_s) begin
        phase_r <= 3'd0;
        case (state_r)
          ST_SEARCH: begin
            // A completed run takes priority over an offset slip on the same word.
            if (is_token_s && (run_cnt_r == RUN_LAST)) begin
              state_r      <= ST_LOCKED;
              locked_r     <= 1'b1;
              word_valid_r <= 1'b1;
              de_r         <= 1'b0;
              data_r       <= 8'd0;
              ctrl_r       <= token_ctrl_s;
              run_cnt_r    <= RUN_W'(0);
              search_cnt_r <= SRCH_W'(0);
              idle_cnt_r   <= IDLE_W'(0);
            end else begin
              de_r   <= 1'b0;
              data_r <= 8'd0;
              ctrl_r <= 2'd0;
              if (search_cnt_r == SEARCH_LAST) begin
                offset_r     <= next_offset_s;
                run_cnt_r    <= RUN_W'(0);
                search_cnt_r <= SRCH_W'(0);
              end else begin
                search_cnt_r <= search_cnt_r + SRCH_W'(1);
                if (is_token_s) begin
                  run_cnt_r <= run_cnt_r + RUN_W'(1);
                end else begin
                  run_cnt_r <= RUN_W'(0);
                end
              end
            end
          end
          ST_LOCKED: begin
            word_valid_r <= 1'b1;
            if (is_token_s) begin
              de_r       <= 1'b0;
              data_r     <= 8'd0;
              ctrl_r     <= token_ctrl_s;
              idle_cnt_r <= IDLE_W'(0);
            end else begin
              de_r   <= 1'b1;
              data_r <= decoded_s;
              // Too long without a token: assume lost alignment and try the next offset.
              if (idle_cnt_r == IDLE_LAST) begin
                state_r      <= ST_SEARCH;
                locked_r     <= 1'b0;
                offset_r     <= next_offset_s;
                run_cnt_r    <= RUN_W'(0);
                search_cnt_r <= SRCH_W'(0);
                idle_cnt_r   <= IDLE_W'(0);
              end else begin
                idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
              end
            end
          end
          default: begin
            state_r      <= ST_SEARCH;
            locked_r     <= 1'b0;
            run_cnt_r    <= RUN_W'(0);
            search_cnt_r <= SRCH_W'(0);
            idle_cnt_r   <= IDLE_W'(0);
          end
        endcase
      end else begin
        phase_r <= phase_r + 3'd1;
      end
    end
  end

  assign bus.word_valid = word_valid_r;
  assign bus.de         = de_r;
  assign bus.data       = data_r;
  assign bus.ctrl       = ctrl_r;
  assign bus.locked     = locked_r;
  assign bus.bit_offset = offset_r;

endmodule

// File: tb/tb_tmds_channel_rx.sv
// Self-checking bench for tmds_channel_rx: serial bit queue driver,
// expected-symbol scoreboard, table of decode vectors, and multi-cycle
// sequences for lock, offset search, lock timeout and reset on a capture edge.
`timescale 1ns/1ps
module tb_tmds_channel_rx;

  typedef struct packed {
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       locked;
  } exp_t;

  typedef struct packed {
    logic [9:0] word;
    exp_t       exp;
  } vec_t;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] DAT10 = 10'b0111110000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic bitq[$];
  exp_t mon_e;
  vec_t vecs[10];

  tmds_channel_rx_if bus_if();

  tmds_channel_rx u_dut (
    .clk_x5 (clk),
    .reset  (reset),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk_exp(input logic de, input logic [7:0] data,
                                  input logic [1:0] ctrl, input logic locked);
    exp_t e;
    e.de     = de;
    e.data   = data;
    e.ctrl   = ctrl;
    e.locked = locked;
    return e;
  endfunction

  // Scoreboard: every word_valid strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus_if.word_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word_valid: got de=%0b data=%02h ctrl=%0b locked=%0b, required no strobe",
                 bus_if.de, bus_if.data, bus_if.ctrl, bus_if.locked);
      end else begin
        mon_e = sb_q.pop_front();
        if ({bus_if.de, bus_if.data, bus_if.ctrl, bus_if.locked} !== mon_e) begin
          errors++;
          $display("FAIL symbol: got de=%0b data=%02h ctrl=%0b locked=%0b, required de=%0b data=%02h ctrl=%0b locked=%0b",
                   bus_if.de, bus_if.data, bus_if.ctrl, bus_if.locked,
                   mon_e.de, mon_e.data, mon_e.ctrl, mon_e.locked);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic push_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) bitq.push_back(w[i]);
  endtask

  // Drive one pair from the bit queue (called at a falling edge).
  task automatic drive_pair();
    bus_if.in_bits = {bitq[1], bitq[0]};
    void'(bitq.pop_front());
    void'(bitq.pop_front());
  endtask

  // One capture period of 5 pairs; the expectation is queued before the strobe appears.
  task automatic drive_capture(input logic exp_v, input exp_t e);
    for (int p = 0; p < 5; p++) begin
      drive_pair();
      if (p == 4 && exp_v) sb_q.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word_valid"}, 32'(bus_if.word_valid), 32'd0);
    check({tag, "_de"},         32'(bus_if.de),         32'd0);
    check({tag, "_data"},       32'(bus_if.data),       32'd0);
    check({tag, "_ctrl"},       32'(bus_if.ctrl),       32'd0);
    check({tag, "_locked"},     32'(bus_if.locked),     32'd0);
    check({tag, "_bit_offset"}, 32'(bus_if.bit_offset), 32'd0);
  endtask

  // Hold reset 3 cycles with random pairs, check outputs, release at a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) begin
      bus_if.in_bits = 2'($urandom);
      @(negedge clk);
    end
    check_all_zero("reset");
    bitq.delete();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{word: 10'b0111110000, exp: mk_exp(1'b1, 8'h10, 2'b00, 1'b1)};
    vecs[1] = '{word: 10'b1011110000, exp: mk_exp(1'b1, 8'hEF, 2'b00, 1'b1)};
    vecs[2] = '{word: 10'b0100000000, exp: mk_exp(1'b1, 8'h00, 2'b00, 1'b1)};
    vecs[3] = '{word: 10'b0000000000, exp: mk_exp(1'b1, 8'hFE, 2'b00, 1'b1)};
    vecs[4] = '{word: TOK10,          exp: mk_exp(1'b0, 8'h00, 2'b10, 1'b1)};
    vecs[5] = '{word: 10'b0111110000, exp: mk_exp(1'b1, 8'h10, 2'b10, 1'b1)};
    vecs[6] = '{word: TOK11,          exp: mk_exp(1'b0, 8'h00, 2'b11, 1'b1)};
    vecs[7] = '{word: 10'b1100000001, exp: mk_exp(1'b1, 8'h02, 2'b11, 1'b1)};
    vecs[8] = '{word: TOK01,          exp: mk_exp(1'b0, 8'h00, 2'b01, 1'b1)};
    vecs[9] = '{word: TOK00,          exp: mk_exp(1'b0, 8'h00, 2'b00, 1'b1)};

    // Reset state.
    bus_if.in_bits = 2'b00;
    do_reset();

    // Lock on 8 tokens at offset 0.
    for (int w = 0; w < 8; w++) push_word(TOK00);
    for (int w = 0; w < 8; w++) begin
      drive_capture(w == 7, mk_exp(1'b0, 8'h00, 2'b00, 1'b1));
      if (w == 6) check("lock_not_before_8th", 32'(bus_if.locked), 32'd0);
    end
    check("lock_locked", 32'(bus_if.locked), 32'd1);
    check("lock_offset", 32'(bus_if.bit_offset), 32'd0);

    // Decode table while locked.
    for (int v = 0; v < 10; v++) begin
      push_word(vecs[v].word);
      drive_capture(1'b1, vecs[v].exp);
    end

    // Lock timeout: 1024 consecutive data words.
    for (int n = 1; n <= 1024; n++) begin
      push_word(DAT10);
      drive_capture(1'b1, mk_exp(1'b1, 8'h10, 2'b00, (n == 1024) ? 1'b0 : 1'b1));
      if (n == 1023) check("timeout_still_locked", 32'(bus_if.locked), 32'd1);
    end
    check("timeout_unlocked", 32'(bus_if.locked), 32'd0);
    check("timeout_offset", 32'(bus_if.bit_offset), 32'd1);
    for (int n = 0; n < 10; n++) begin
      push_word(DAT10);
      drive_capture(1'b0, mk_exp(1'b0, 8'h00, 2'b00, 1'b0));
    end
    check("after_timeout_locked", 32'(bus_if.locked), 32'd0);

    // Offset search: 3 junk bits then repeated token 01.
    do_reset();
    bitq.push_back(1'b1);
    bitq.push_back(1'b0);
    bitq.push_back(1'b1);
    for (int c = 1; c <= 470; c++) begin
      while (bitq.size() < 10) push_word(TOK01);
      drive_capture(c >= 456, mk_exp(1'b0, 8'h00, 2'b01, 1'b1));
      if ((c % 64) == 0 && c <= 448) check("search_offset", 32'(bus_if.bit_offset), 32'(c / 64));
      if (c == 455) check("search_not_locked", 32'(bus_if.locked), 32'd0);
      if (c == 456) begin
        check("search_locked", 32'(bus_if.locked), 32'd1);
        check("search_lock_offset", 32'(bus_if.bit_offset), 32'd7);
      end
    end

    // Reset asserted on a capture edge while locked.
    while (bitq.size() < 10) push_word(TOK01);
    for (int p = 0; p < 5; p++) begin
      drive_pair();
      if (p == 4) reset = 1'b1;
      @(negedge clk);
    end
    check_all_zero("capture_reset");
    bitq.delete();
    reset = 1'b0;
    for (int w = 0; w < 8; w++) push_word(TOK10);
    for (int w = 0; w < 8; w++) begin
      drive_capture(w == 7, mk_exp(1'b0, 8'h00, 2'b10, 1'b1));
    end
    check("relock_locked", 32'(bus_if.locked), 32'd1);
    check("relock_offset", 32'(bus_if.bit_offset), 32'd0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
